dm_access_ctrl: RTL
===================

# dm_access_ctrl

Data-memory access controller between the single-cycle CPU's load/store port and the word-wide data memory `dm`. Accepts one byte/halfword/word request at a time via a valid/ready handshake. Performs sign/zero extension for loads and read-modify-write merging for sub-word stores. Flags misaligned or illegal accesses without touching memory. Word-addressed memory side: read is combinational, write is synchronous.

## Interface

Parameters:
- `ADDR_W`, default 7: word-address width to memory. The memory address is `req_addr[ADDR_W+1:2]`.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low byte or halfword is used for sub-word stores.
- `req_funct3`  in  3  RISC-V funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  extended load data.
- `rsp_err`  out  1  completion was misaligned or illegal; valid with `rsp_valid`.
- `mem_we`  out  1  write strobe to `dm`.
- `mem_addr`  out  ADDR_W  word address to `dm`.
- `mem_wdata`  out  32  full word to `dm`.
- `mem_rdata`  in  32  `dm` combinational read data for `mem_addr`.

## Operation

- FSM states: IDLE, RD, WR, RESP.
- Acceptance: at a rising edge with `req_valid`=1 in IDLE. At that edge the controller latches `req_we`, `req_addr`, `req_wdata` and `req_funct3` into internal registers. Request inputs are ignored at every other time.
- Classification at acceptance, with the resulting next state:
  - Error (next RESP, `rsp_err`=1), any of:
    - funct3 is 011, 110 or 111;
    - store with funct3 100 or 101;
    - halfword access with `addr[0]`=1;
    - word access with `addr[1:0]`≠0.
  - Load: next RD.
  - SW: next WR.
  - SB or SH: next RD.
- RD:
  - `mem_addr` comes from the latched address.
  - At the edge ending RD the controller captures `mem_rdata`.
  - Load: extracts the lane into `rsp_rdata`, then goes to RESP.
    - LB/LBU: byte lane `addr[1:0]`, sign- or zero-extended.
    - LH/LHU: halfword lane `addr[1]`, sign- or zero-extended.
    - LW: full word.
  - SB/SH: stores the merged word into the write register, then goes to WR.
    - SB replaces byte lane `addr[1:0]` with `wdata[7:0]`.
    - SH replaces halfword lane `addr[1]` with `wdata[15:0]`.
- WR:
  - `mem_we`=1 and `mem_wdata` is the write register. For SW the write register is `req_wdata` as latched.
  - Next state RESP.
- RESP:
  - `rsp_valid`=1 for exactly one cycle, then IDLE.
  - `rsp_rdata` is 0 for stores and errors.
  - `rsp_err` is 0 unless the request was an error.
- `mem_we`, `rsp_valid` and `req_ready` decode combinationally from the state register only.
- `mem_addr` is always driven from the latched address.
- An error request never asserts `mem_we`.
- Outside RESP, `rsp_rdata` and `rsp_err` hold their last values.

## Timing

- Reset (`rstn` low, asynchronous), all values take effect immediately:
  - state = IDLE;
  - all internal registers = 0;
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0;
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `req_ready`=1.
- No acceptance occurs while `rstn` is low.
- Reset mid-operation aborts the request with no response.
  - If it occurs in WR, `mem_we` drops at once and no write occurs.
- Latency, counted as acceptance edge E0 to the cycle in which `rsp_valid` is high:
  - load: RD during E0–E1, RESP during E1–E2;
  - SW: WR during E0–E1 (`dm` written at E1), RESP during E1–E2;
  - SB/SH: RD E0–E1, WR E1–E2, RESP E2–E3;
  - error: RESP during E0–E1.
- `req_ready` is low from E0 until the edge that returns the FSM to IDLE. The earliest next acceptance is therefore that edge plus one cycle.
- Maximum throughput is one request per 2 (error), 3 (load/SW) or 4 (SB/SH) cycles.
- `req_valid` may stay high across busy cycles. Held requests are not double-accepted: only IDLE edges accept.

## Test plan

- Reset and SW/LW round trip:
  - Stimulus: assert then release `rstn`; SW `wdata`=0xDEADBEEF at `addr`=0x10; then LW at 0x10.
  - Response: during reset, outputs are 0 and `req_ready`=1. The SW writes `mem_addr`=4 with `mem_we` high for exactly one cycle. The LW gives `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, two cycles after acceptance.
- Sub-word RMW:
  - Stimulus: word 0x11223344 at 0x20; SB `wdata`=0xAA at 0x21; then SH `wdata`=0xBEEF at 0x22; then LW at 0x20.
  - Response: `mem_wdata` after the SB is 0x1122AA44. After the SH it is 0xBEEFAA44. The final LW returns 0xBEEFAA44. Each store responds three cycles after acceptance.
- Load extension on word 0x80FF7F01 at 0x30:
  - LB 0x32 → 0xFFFFFFFF.
  - LBU 0x32 → 0x000000FF.
  - LB 0x30 → 0x00000001.
  - LH 0x32 → 0xFFFF80FF.
  - LHU 0x32 → 0x000080FF.
- Errors:
  - Stimulus: LW 0x31; SH 0x33; store funct3=100; load funct3=011.
  - Response: each gives `rsp_valid` one cycle after acceptance with `rsp_err`=1 and `rsp_rdata`=0. `mem_we` stays 0 throughout. Memory is unchanged, checked by a later LW.
- Handshake and reset abort:
  - Stimulus 1: hold `req_valid` high continuously with alternating requests.
    - Response: exactly one acceptance per IDLE edge, and no duplicate writes.
  - Stimulus 2: drop `rstn` during the WR of an SB.
    - Response: `mem_we` falls immediately, the target word keeps its old value, and no `rsp_valid` occurs.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// Load/store controller between the CPU data port and a word-wide memory.
// Handles sub-word extraction and sign/zero extension, read-modify-write stores, and alignment errors.
module dm_access_ctrl #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state, state_nxt;
  logic              we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q, wreg_q, rdata_q;
  logic [2:0]        f3_q;
  logic              err_q;

  logic        f3_bad, st_bad, misal, req_err, req_sw;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data, merged;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign f3_bad  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
  assign st_bad  = req_we && req_funct3[2];
  assign misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_err = f3_bad || st_bad || misal;
  assign req_sw  = req_we && (req_funct3 == 3'b010);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = req_err ? RESP : (req_sw ? WR : RD);
      RD:   state_nxt = we_q ? WR : RESP;
      WR:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores share the same read word.
  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_data = f3_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ld_data = f3_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ld_data = mem_rdata;
    endcase
    merged = mem_rdata;
    if (f3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      wreg_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          addr_q  <= req_addr[ADDR_W+1:0];
          wdata_q <= req_wdata;
          f3_q    <= req_funct3;
          if (req_err) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else if (req_sw) begin
            wreg_q  <= req_wdata;
          end
        end
        RD: if (we_q) wreg_q <= merged;
            else begin
              rdata_q <= ld_data;
              err_q   <= 1'b0;
            end
        WR: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_we    = (state == WR);
  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign mem_wdata = wreg_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule
